// File: rtl/pdp8_ifd.sv
// -----------------------------------------------------------------------------
// pdp8_ifd_pkg / pdp8_ifd
//
// PDP-8 instruction fetch/decode unit. Fetches one 12-bit word at the current
// PC, decodes it into one-hot opcode flags for the execute unit, then waits for
// the execute unit's stall handshake. When stall falls, the next PC is taken
// from PC_value. The unit halts for good (until reset) when execute hands back
// BASE_ADDR as the next PC.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-high reset
//   ifu_rd_req      one-cycle memory read request
//   ifu_rd_addr     read address, valid with ifu_rd_req (0 otherwise)
//   ifu_rd_valid    ifu_rd_data is valid (honoured only while awaiting data)
//   ifu_rd_data     fetched instruction word
//   stall           execute busy; PC_value is taken when it is seen low
//   PC_value        next PC supplied by execute
//   base_addr       constant BASE_ADDR
//   pdp_mem_opcode  memory-reference one-hot flags + 9-bit operand address
//   pdp_op7_opcode  group-7 microinstruction one-hot flags
// -----------------------------------------------------------------------------

package pdp8_ifd_pkg;

  // Memory-reference instructions: opcode field 0..5 plus the 9-bit
  // page/indirect/offset operand field.
  typedef struct packed {
    logic       op_and;
    logic       op_tad;
    logic       op_isz;
    logic       op_dca;
    logic       op_jms;
    logic       op_jmp;
    logic [8:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  // Group-7 microinstructions recognised by exact word match.
  typedef struct packed {
    logic nop;
    logic iac;
    logic ral;
    logic rtl;
    logic rar;
    logic rtr;
    logic cml;
    logic cma;
    logic cia;
    logic cll;
    logic cla1;
    logic cla_cll;
    logic hlt;
    logic osr;
    logic skp;
    logic snl;
    logic szl;
    logic sza;
    logic sna;
    logic sma;
    logic spa;
    logic cla2;
  } pdp_op7_opcode_s;

endpackage

module pdp8_ifd
  import pdp8_ifd_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(12'o200)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic                  ifu_rd_valid,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] PC_value,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode
);

  typedef enum logic [2:0] {
    FETCH,
    WAIT_MEM,
    DECODE,
    ISSUE,
    STALLED,
    DONE
  } state_e;

  state_e                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;

  pdp_mem_opcode_s dec_mem;
  pdp_op7_opcode_s dec_op7;
  logic            dec_valid;

  assign base_addr = BASE_ADDR;

  // ---------------------------------------------------------------------------
  // Instruction decode of the latched word. Only the registered copies made in
  // DECODE ever reach the outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    dec_mem   = '0;
    dec_op7   = '0;
    dec_valid = 1'b1;

    case (ir[11:9])
      3'o0: dec_mem.op_and = 1'b1;
      3'o1: dec_mem.op_tad = 1'b1;
      3'o2: dec_mem.op_isz = 1'b1;
      3'o3: dec_mem.op_dca = 1'b1;
      3'o4: dec_mem.op_jms = 1'b1;
      3'o5: dec_mem.op_jmp = 1'b1;
      3'o6: dec_valid = 1'b0;             // IOT: not handled by this unit
      default: begin
        // Group 7: only the exact combinations below are issued; any other
        // microcoded word is skipped like an IOT.
        case (ir)
          12'o7000: dec_op7.nop     = 1'b1;
          12'o7001: dec_op7.iac     = 1'b1;
          12'o7004: dec_op7.ral     = 1'b1;
          12'o7006: dec_op7.rtl     = 1'b1;
          12'o7010: dec_op7.rar     = 1'b1;
          12'o7012: dec_op7.rtr     = 1'b1;
          12'o7020: dec_op7.cml     = 1'b1;
          12'o7040: dec_op7.cma     = 1'b1;
          12'o7041: dec_op7.cia     = 1'b1;
          12'o7100: dec_op7.cll     = 1'b1;
          12'o7200: dec_op7.cla1    = 1'b1;
          12'o7300: dec_op7.cla_cll = 1'b1;
          12'o7402: dec_op7.hlt     = 1'b1;
          12'o7404: dec_op7.osr     = 1'b1;
          12'o7410: dec_op7.skp     = 1'b1;
          12'o7420: dec_op7.snl     = 1'b1;
          12'o7430: dec_op7.szl     = 1'b1;
          12'o7440: dec_op7.sza     = 1'b1;
          12'o7450: dec_op7.sna     = 1'b1;
          12'o7500: dec_op7.sma     = 1'b1;
          12'o7510: dec_op7.spa     = 1'b1;
          12'o7600: dec_op7.cla2    = 1'b1;
          default:  dec_valid       = 1'b0;
        endcase
      end
    endcase

    // The operand field only means something for memory-reference opcodes.
    if (ir[11:9] < 3'o6) begin
      dec_mem.mem_inst_addr = ir[8:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. All outputs are registered here so the execute unit sees
  // glitch-free flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    if (reset) begin
      // NOTE: every register is reset, including IR, so nothing stale from a
      // read aborted by reset can leak into a later decode.
      state          <= FETCH;
      pc             <= BASE_ADDR;
      ir             <= '0;
      ifu_rd_req     <= 1'b0;
      ifu_rd_addr    <= '0;
      pdp_mem_opcode <= '0;
      pdp_op7_opcode <= '0;
    end else begin
      // Request and address are single-cycle pulses; they default low.
      ifu_rd_req  <= 1'b0;
      ifu_rd_addr <= '0;

      case (state)
        FETCH: begin
          ifu_rd_req  <= 1'b1;
          ifu_rd_addr <= pc;
          state       <= WAIT_MEM;
        end

        WAIT_MEM: begin
          if (ifu_rd_valid) begin
            ir    <= ifu_rd_data;
            state <= DECODE;
          end
        end

        DECODE: begin
          if (dec_valid) begin
            pdp_mem_opcode <= dec_mem;
            pdp_op7_opcode <= dec_op7;
            state          <= ISSUE;
          end else begin
            // Nothing to hand to execute: step over the word ourselves.
            pc    <= pc + ADDR_WIDTH'(1);
            state <= FETCH;
          end
        end

        ISSUE: begin
          // Flags stay up until execute acknowledges by raising stall; if
          // stall is already high they are seen for exactly this one cycle.
          if (stall) begin
            pdp_mem_opcode <= '0;
            pdp_op7_opcode <= '0;
            state          <= STALLED;
          end
        end

        STALLED: begin
          if (!stall) begin
            // Execute returning to the start address is the end-of-program
            // marker.
            if (PC_value == BASE_ADDR) begin
              state <= DONE;
            end else begin
              pc    <= PC_value;
              state <= FETCH;
            end
          end
        end

        DONE: state <= DONE;

        default: state <= FETCH;
      endcase
    end
  end

endmodule
